kpn_queue_write_arbiter: RTL and testbench
==========================================

Name: kpn_queue_write_arbiter

Overview:
Round-robin write arbiter sharing one KPN channel FIFO among NUM_PRODUCERS producer processes.
Grants one producer per cycle and lets the owner keep the grant for bursts of up to MAX_BURST tokens.
Drives the FIFO write strobe and data as registered outputs.
Enforces KPN blocking-write semantics: a producer stalls while the FIFO is full, and no token is ever dropped or duplicated.

Parameters:
BITS_NUMBER, 16, token width in bits
NUM_PRODUCERS, 4, number of requesting producers (2..8)
MAX_BURST, 4, maximum consecutive tokens one owner may write before re-arbitration (>=1)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
req  in  NUM_PRODUCERS  per-producer write request; level held until granted
data_in  in  NUM_PRODUCERS*BITS_NUMBER  flattened producer tokens; producer i at bits [i*BITS_NUMBER +: BITS_NUMBER]
full  in  1  FIFO full flag
almost_full  in  1  FIFO has exactly one free slot
gnt  out  NUM_PRODUCERS  one-hot, combinational; gnt[i]=1 means producer i's token is accepted this cycle
wr  out  1  registered FIFO write strobe
data_out  out  BITS_NUMBER  registered token to FIFO
owner  out  clog2(NUM_PRODUCERS)  current or last owner index

Behaviour:
- Reset: wr=0, data_out=0, owner=NUM_PRODUCERS-1 (so producer 0 wins first), burst_cnt=0, state=IDLE.
- can_accept = !full && !(wr && almost_full). The second term covers the in-flight write.
- IDLE:
  - If any req and can_accept: pick the first requester searching from owner+1 mod N, wrapping.
  - gnt that requester; owner<=pick; burst_cnt<=1.
  - Go to OWN if MAX_BURST>1, else stay in IDLE.
- OWN:
  - If req[owner] && can_accept && burst_cnt<MAX_BURST: gnt[owner]; burst_cnt++.
  - If req[owner] is low, or burst_cnt==MAX_BURST: release. In that same cycle, arbitrate as in IDLE, searching from owner+1 with the old owner lowest priority. No bubble on handover.
  - If req[owner] && !can_accept: hold ownership, no gnt, burst_cnt unchanged (stall).
- Write path:
  - On an accepting edge: data_out<=selected data_in; wr<=1.
  - Otherwise wr<=0 and data_out holds its last value.
  - Latency: token visible at FIFO one cycle after gnt.
- At most one gnt bit is high per cycle. gnt is never asserted when can_accept=0.
- Requests arriving while full: no grant, no state change in IDLE.
- Single requester with req held continuously: releases after MAX_BURST, re-arbitration finds the same requester, new burst starts the next cycle. Throughput stays 1 token/cycle.
- Reset asserted mid-burst: all state returns to reset values at that edge; wr=0 the following cycle. Pending tokens stay with producers (req still held).

Optional Feature:
- Macro: KPN_ARB_STALL_CNT_EN.
- Defined: adds output stall_cnt, 16 bits. It increments on every cycle where |req && !can_accept, saturates at 16'hFFFF, and clears on reset.
- Undefined: the port and counter are absent; arbitration behaviour is identical.

Decomposition:
- Shared package kpn_pkg: BITS_NUMBER default, the arbiter state enum (IDLE, OWN), and a token typedef of width BITS_NUMBER.
- One sub-module, kpn_rr_pick: combinational round-robin picker.
  - Inputs: req vector, start index.
  - Outputs: one-hot pick and index, plus valid.

Test Plan:
- reset, then req=4'b0101, FIFO empty -> gnt=0001 for 4 cycles (MAX_BURST), then gnt=0100 for 4 cycles; wr pulses continuously one cycle behind gnt; data_out follows the tokens.
- req=4'b1111, producer i sends token 16'h00i0+n -> service order 0,1,2,3,0 in bursts of 4; all tokens appear in FIFO order with no loss.
- owner=1 mid-burst, full=1 for 3 cycles -> gnt=0, wr=0, owner stays 1, burst_cnt frozen; grant resumes at producer 1 when full drops.
- almost_full=1 and wr=1 in the same cycle -> no gnt that cycle; next cycle full=1 and still no gnt; FIFO never overflows.
- reset asserted while owner=2 with burst_cnt=2 -> next cycle wr=0, data_out=0, owner=3; first grant afterwards goes to the lowest requesting index.
- KPN_ARB_STALL_CNT_EN defined, req=0001 held for 10 cycles with full=1 -> stall_cnt=10; after reset stall_cnt=0.

Source files
------------

// File: rtl/kpn_pkg.sv
// Shared types for the KPN channel write arbiter: default token width,
// arbiter state encoding and the token type.
package kpn_pkg;

  localparam int unsigned BITS_NUMBER_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  typedef logic [BITS_NUMBER_DEF-1:0] token_t;

endpackage

// File: rtl/kpn_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or after
// start_i, wrapping modulo N.
module kpn_rr_pick
  import kpn_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int unsigned cand;
    cand    = 0;
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(start_i) + k) % N;
      if (!valid_o && req_i[IW'(cand)]) begin
        valid_o            = 1'b1;
        idx_o              = IW'(cand);
        pick_o[IW'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kpn_queue_write_arbiter.sv
// Round-robin burst write arbiter sharing one KPN channel FIFO among producers.
// Optional KPN_ARB_STALL_CNT_EN adds a saturating 16-bit stall counter output.
module kpn_queue_write_arbiter
  import kpn_pkg::*;
#(
  parameter int unsigned BITS_NUMBER   = BITS_NUMBER_DEF,
  parameter int unsigned NUM_PRODUCERS = 4,
  parameter int unsigned MAX_BURST     = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_PRODUCERS-1:0]               req,
  input  logic [NUM_PRODUCERS*BITS_NUMBER-1:0]   data_in,
  input  logic                                   full,
  input  logic                                   almost_full,
  output logic [NUM_PRODUCERS-1:0]               gnt,
  output logic                                   wr,
  output logic [BITS_NUMBER-1:0]                 data_out,
  output logic [$clog2(NUM_PRODUCERS)-1:0]       owner
`ifdef KPN_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                            stall_cnt
`endif
);

  localparam int unsigned OW = $clog2(NUM_PRODUCERS);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [OW-1:0] LAST_IDX = OW'(NUM_PRODUCERS - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam arb_state_e BURST_STATE = (MAX_BURST > 1) ? OWN : IDLE;

  arb_state_e               state_q, state_d;
  logic [OW-1:0]            owner_q, owner_d;
  logic [BW-1:0]            burst_q, burst_d;
  logic                     wr_q;
  logic [BITS_NUMBER-1:0]   data_q;

  logic                     can_accept_c;
  logic                     arbitrate_c;
  logic                     accept_c;
  logic [OW-1:0]            sel_c;
  logic [OW-1:0]            start_c;
  logic [NUM_PRODUCERS-1:0] pick_vec;
  logic [OW-1:0]            pick_idx;
  logic                     pick_valid;
  logic [BITS_NUMBER-1:0]   tok_c [NUM_PRODUCERS];

  for (genvar i = 0; i < NUM_PRODUCERS; i++) begin : g_tok
    assign tok_c[i] = data_in[i*BITS_NUMBER +: BITS_NUMBER];
  end

  // A write already in flight consumes the last free slot.
  assign can_accept_c = !full && !(wr_q && almost_full);
  assign start_c      = (owner_q == LAST_IDX) ? '0 : OW'(owner_q + OW'(1));

  kpn_rr_pick #(
    .N  (NUM_PRODUCERS),
    .IW (OW)
  ) u_pick (
    .req_i   (req),
    .start_i (start_c),
    .pick_o  (pick_vec),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Release (owner idle or burst spent) re-arbitrates in the same cycle.
  assign arbitrate_c = (state_q == IDLE) ||
                       !(req[owner_q] && (burst_q < BURST_MAX));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    gnt      = '0;
    accept_c = 1'b0;
    sel_c    = owner_q;
    if (!reset) begin
      if (arbitrate_c) begin
        if (pick_valid && can_accept_c) begin
          gnt      = pick_vec;
          accept_c = 1'b1;
          sel_c    = pick_idx;
          owner_d  = pick_idx;
          burst_d  = BW'(1);
          state_d  = BURST_STATE;
        end else begin
          state_d  = IDLE;
        end
      end else if (can_accept_c) begin
        gnt[owner_q] = 1'b1;
        accept_c     = 1'b1;
        burst_d      = BW'(burst_q + BW'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= LAST_IDX;
      burst_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      wr_q    <= accept_c;
      if (accept_c) begin
        data_q <= tok_c[sel_c];
      end
    end
  end

  assign wr       = wr_q;
  assign data_out = data_q;
  assign owner    = owner_q;

`ifdef KPN_ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (|req && !can_accept_c && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_kpn_queue_write_arbiter.sv
// Table-driven bench for kpn_queue_write_arbiter with a token scoreboard.
module tb_kpn_queue_write_arbiter;
  import kpn_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned B  = 16;
  localparam int unsigned MB = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*B-1:0]   data_in;
  logic             full;
  logic             almost_full;
  logic [N-1:0]     gnt;
  logic             wr;
  logic [B-1:0]     data_out;
  logic [1:0]       owner;
`ifdef KPN_ARB_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  always #5 clk = ~clk;

  kpn_queue_write_arbiter #(
    .BITS_NUMBER   (B),
    .NUM_PRODUCERS (N),
    .MAX_BURST     (MB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .data_in     (data_in),
    .full        (full),
    .almost_full (almost_full),
    .gnt         (gnt),
    .wr          (wr),
    .data_out    (data_out),
    .owner       (owner)
`ifdef KPN_ARB_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         full;
    logic         af;
    logic [N-1:0] gnt;
    logic [1:0]   owner;
  } vec_t;

  vec_t       vecs[$];
  token_t     exp_q[$];
  logic [7:0] sent [N];
  int         errors = 0;
  int         checks = 0;

  function automatic void add(input logic rst, input logic [N-1:0] rq, input logic fl,
                              input logic af, input logic [N-1:0] g, input logic [1:0] ow);
    vec_t v;
    v.rst = rst; v.req = rq; v.full = fl; v.af = af; v.gnt = g; v.owner = ow;
    vecs.push_back(v);
  endfunction

  function automatic token_t tok(input int i);
    return token_t'((i << 8) | int'(sent[i]));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_tokens();
    for (int i = 0; i < N; i++) data_in[i*B +: B] = tok(i);
  endtask

  // Called 1 time unit after a rising edge; returns at the same point a cycle later.
  task automatic apply(input vec_t v, input int n);
    logic   pushed;
    token_t e;
    reset = v.rst; req = v.req; full = v.full; almost_full = v.af;
    drive_tokens();
    @(negedge clk);
    check($sformatf("gnt[%0d]", n), 32'(gnt), 32'(v.gnt));
    pushed = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (v.gnt[i]) begin
        exp_q.push_back(tok(i));
        sent[i] = sent[i] + 8'd1;
        pushed  = 1'b1;
      end
    end
    @(posedge clk); #1;
    check($sformatf("wr[%0d]", n), 32'(wr), 32'(pushed));
    if (pushed) begin
      e = exp_q.pop_front();
      check($sformatf("data_out[%0d]", n), 32'(data_out), 32'(e));
    end
    check($sformatf("owner[%0d]", n), 32'(owner), 32'(v.owner));
    if (v.rst) check($sformatf("rst_data_out[%0d]", n), 32'(data_out), 32'h0);
  endtask

  initial begin
    int     waited;
    token_t e;
    for (int i = 0; i < N; i++) sent[i] = 8'd0;
    reset = 1'b1; req = '0; full = 1'b0; almost_full = 1'b0;
    drive_tokens();

    // reset
    add(1, 4'b0000, 0, 0, 4'b0000, 2'd3);
    add(1, 4'b0000, 0, 0, 4'b0000, 2'd3);
    // two requesters, bursts of MAX_BURST
    for (int k = 0; k < 4; k++) add(0, 4'b0101, 0, 0, 4'b0001, 2'd0);
    for (int k = 0; k < 4; k++) add(0, 4'b0101, 0, 0, 4'b0100, 2'd2);
    add(0, 4'b0101, 0, 0, 4'b0001, 2'd0);
    add(0, 4'b0000, 0, 0, 4'b0000, 2'd0);
    // all requesting, rotation 1,2,3,0,1
    for (int k = 0; k < 4; k++) add(0, 4'b1111, 0, 0, 4'b0010, 2'd1);
    for (int k = 0; k < 4; k++) add(0, 4'b1111, 0, 0, 4'b0100, 2'd2);
    for (int k = 0; k < 4; k++) add(0, 4'b1111, 0, 0, 4'b1000, 2'd3);
    for (int k = 0; k < 4; k++) add(0, 4'b1111, 0, 0, 4'b0001, 2'd0);
    add(0, 4'b1111, 0, 0, 4'b0010, 2'd1);
    // full stall mid-burst of owner 1
    add(0, 4'b1111, 0, 0, 4'b0010, 2'd1);
    for (int k = 0; k < 3; k++) add(0, 4'b1111, 1, 0, 4'b0000, 2'd1);
    add(0, 4'b1111, 0, 0, 4'b0010, 2'd1);
    add(0, 4'b1111, 0, 0, 4'b0010, 2'd1);
    add(0, 4'b1111, 0, 0, 4'b0100, 2'd2);
    // almost_full with a write in flight
    add(0, 4'b1111, 0, 1, 4'b0000, 2'd2);
    add(0, 4'b1111, 1, 0, 4'b0000, 2'd2);
    add(0, 4'b1111, 0, 1, 4'b0100, 2'd2);
    add(0, 4'b1111, 0, 1, 4'b0000, 2'd2);
    // reset with owner 2, burst 2
    add(1, 4'b1111, 0, 0, 4'b0000, 2'd3);
    add(0, 4'b1010, 0, 0, 4'b0010, 2'd1);
    add(0, 4'b0000, 0, 0, 4'b0000, 2'd1);
    // single requester keeps full throughput across bursts
    for (int k = 0; k < 7; k++) add(0, 4'b0001, 0, 0, 4'b0001, 2'd0);
    add(0, 4'b0000, 0, 0, 4'b0000, 2'd0);
    // requests while full in IDLE
    add(0, 4'b0100, 1, 0, 4'b0000, 2'd0);
    add(0, 4'b0100, 1, 0, 4'b0000, 2'd0);

    @(posedge clk); #1;
    for (int n = 0; n < vecs.size(); n++) apply(vecs[n], n);

    // full held, then released: grant must follow within a bounded wait
    reset = 1'b0; req = 4'b0100; full = 1'b1; almost_full = 1'b0;
    drive_tokens();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hold_gnt[%0d]", k), 32'(gnt), 32'h0);
      @(posedge clk); #1;
      check($sformatf("hold_wr[%0d]", k), 32'(wr), 32'h0);
    end
    full = 1'b0;
    waited = 0;
    @(negedge clk);
    while (gnt == '0 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("resume_gnt", 32'(gnt), 32'(4'b0100));
    if (gnt == 4'b0100) begin
      exp_q.push_back(tok(2));
      sent[2] = sent[2] + 8'd1;
      @(posedge clk); #1;
      req = '0;
      check("resume_wr", 32'(wr), 32'h1);
      e = exp_q.pop_front();
      check("resume_data", 32'(data_out), 32'(e));
      check("resume_owner", 32'(owner), 32'd2);
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

`ifdef KPN_ARB_STALL_CNT_EN
    reset = 1'b1; req = '0; full = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; req = 4'b0001; full = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("stall_cnt_10", 32'(stall_cnt), 32'd10);
    reset = 1'b1;
    @(posedge clk); #1;
    check("stall_cnt_rst", 32'(stall_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
